multi_add_seq: RTL

- Multi-cycle controller that computes a W-bit add/subtract through one 2**S-bit adder slice, one chunk per cycle, least significant chunk first.
- Carry is registered between chunks.
- Lets narrow arithmetic units serve wide operands without instantiating a full-width ripple chain.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/multi_add_seq.sv | 133 +++++++++++++
 1 files changed

// File: rtl/multi_add_seq.sv
// Chunk-serial add/subtract: one 2**S-bit slice adder walks K chunks LSB-first,
// carrying between chunks in a register, with valid/ready on both sides.

module slice_add #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          ci,
  output logic [SW-1:0] sum,
  output logic          co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};
endmodule

module multi_add_seq #(
  parameter int S = 3,
  parameter int K = 4,
  localparam int SW = 2 ** S,
  localparam int W = K * SW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         busy
);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          carry_reg, carry_next;
  logic [W-1:0]  a_reg, a_next;
  logic [W-1:0]  b_reg, b_next;
  logic [W-1:0]  s_reg, s_next;
  logic          cout_reg, cout_next;

  logic [SW-1:0] a_chunk [K];
  logic [SW-1:0] b_chunk [K];
  logic [SW-1:0] slice_sum;
  logic          slice_co;

  genvar gi;
  generate
    for (gi = 0; gi < K; gi++) begin : g_chunk
      assign a_chunk[gi] = a_reg[gi*SW +: SW];
      assign b_chunk[gi] = b_reg[gi*SW +: SW];
    end
  endgenerate

  // b_reg already holds ~b for subtraction, so the slice only ever adds.
  slice_add #(.SW(SW)) u_slice (
    .a  (a_chunk[cnt_reg]),
    .b  (b_chunk[cnt_reg]),
    .ci (carry_reg),
    .sum(slice_sum),
    .co (slice_co)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    carry_next = carry_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    s_next     = s_reg;
    cout_next  = cout_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          a_next     = a;
          b_next     = sub ? ~b : b;
          carry_next = cin;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        carry_next = slice_co;
        for (int i = 0; i < K; i++) begin
          if (cnt_reg == CW'(i)) s_next[i*SW +: SW] = slice_sum;
        end
        if (cnt_reg == LAST) begin
          cout_next  = slice_co;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      carry_reg <= carry_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      s_reg     <= s_next;
      cout_reg  <= cout_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign s         = s_reg;
  assign cout      = cout_reg;
endmodule
